k_round_sequencer: RTL and testbench



---
 rtl/k_round_sequencer_pkg.sv | 32 +++
 rtl/k_round_sequencer.sv | 147 ++++++++++++++
 tb/tb_k_round_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/k_round_sequencer_pkg.sv
// Shared hash definitions: opcode encoding, per-algorithm round counts and the
// K-round sequencer state type.
package definitions;

  typedef enum logic [1:0] {
    MD5            = 2'd0,
    SHA_1          = 2'd1,
    SHA_256        = 2'd2,
    OPCODE_RESERVE = 2'd3
  } opcode_t;

  localparam int MD5_ROUNDS    = 64;
  localparam int SHA1_ROUNDS   = 80;
  localparam int SHA256_ROUNDS = 64;
  localparam int SHA1_QUAD_LEN = 20;

  typedef enum logic [1:0] {
    KSEQ_IDLE  = 2'd0,
    KSEQ_RUN   = 2'd1,
    KSEQ_FLUSH = 2'd2
  } kseq_state_t;

  // The reserved opcode is sequenced exactly like SHA-256.
  function automatic int unsigned round_count(opcode_t op);
    case (op)
      MD5:     round_count = MD5_ROUNDS;
      SHA_1:   round_count = SHA1_ROUNDS;
      default: round_count = SHA256_ROUNDS;
    endcase
  endfunction

endpackage

// File: rtl/k_round_sequencer.sv
// Steps through every round of the selected hash, fetches each round's K
// constant from the external lookup and streams (round, K) beats downstream.
module k_round_sequencer
  import definitions::*;
#(
  parameter int ROUND_W = 8,
  parameter int K_W     = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         opcode,
  output logic [ROUND_W-1:0] k_round,
  output logic [1:0]         k_opcode,
  output logic [1:0]         k_quad,
  input  logic [K_W-1:0]     k_val,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROUND_W-1:0] out_round,
  output logic [K_W-1:0]     out_k,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  // Handshake: a beat transfers on a rising edge where out_valid && out_ready.
  // While out_valid is high and out_ready low, out_round/out_k/out_last hold.

  kseq_state_t        state_q, state_d;
  opcode_t            op_q, op_d;
  logic [ROUND_W-1:0] cnt_q, cnt_d;
  logic [1:0]         quad_q, quad_d;
  logic [4:0]         sub_q, sub_d;
  logic               valid_q, valid_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [K_W-1:0]     kval_q, kval_d;
  logic               last_q, last_d;
  logic               done_q, done_d;

  logic [ROUND_W-1:0] last_idx;
  logic               load;
  logic               at_last;

  assign last_idx = ROUND_W'(round_count(op_q) - 32'd1);
  assign load     = !valid_q || out_ready;
  assign at_last  = (cnt_q == last_idx);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= KSEQ_IDLE;
      op_q    <= MD5;
      cnt_q   <= '0;
      quad_q  <= 2'd0;
      sub_q   <= 5'd0;
      valid_q <= 1'b0;
      round_q <= '0;
      kval_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      quad_q  <= quad_d;
      sub_q   <= sub_d;
      valid_q <= valid_d;
      round_q <= round_d;
      kval_q  <= kval_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    quad_d  = quad_q;
    sub_d   = sub_q;
    valid_d = valid_q;
    round_d = round_q;
    kval_d  = kval_q;
    last_d  = last_q;
    done_d  = 1'b0;

    case (state_q)
      KSEQ_IDLE: begin
        if (start) begin
          op_d    = opcode_t'(opcode);
          cnt_d   = '0;
          quad_d  = 2'd0;
          sub_d   = 5'd0;
          state_d = KSEQ_RUN;
        end
      end

      KSEQ_RUN: begin
        if (load) begin
          valid_d = 1'b1;
          round_d = cnt_q;
          kval_d  = k_val;
          last_d  = at_last;
          // The counter stops on the final round; FLUSH drains that beat.
          if (at_last) begin
            state_d = KSEQ_FLUSH;
          end else begin
            cnt_d = cnt_q + ROUND_W'(1);
            if (sub_q == 5'(SHA1_QUAD_LEN - 1)) begin
              sub_d  = 5'd0;
              quad_d = quad_q + 2'd1;
            end else begin
              sub_d = sub_q + 5'd1;
            end
          end
        end
      end

      KSEQ_FLUSH: begin
        if (out_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = KSEQ_IDLE;
        end
      end

      default: state_d = KSEQ_IDLE;
    endcase
  end

  always_comb begin
    case (op_q)
      MD5:     k_quad = cnt_q[5:4];
      SHA_1:   k_quad = quad_q;
      default: k_quad = 2'd0;
    endcase
  end

  assign k_round   = cnt_q;
  assign k_opcode  = op_q;
  assign out_valid = valid_q;
  assign out_round = round_q;
  assign out_k     = kval_q;
  assign out_last  = last_q;
  assign busy      = (state_q != KSEQ_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_k_round_sequencer.sv
// Bench for k_round_sequencer: a stub K lookup, directed hash runs and a
// scoreboard that checks every accepted beat against an expected queue.
module tb_k_round_sequencer;
  import definitions::*;

  localparam int RW = 8;
  localparam int KW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    opcode = 2'd0;
  logic [RW-1:0] k_round;
  logic [1:0]    k_opcode;
  logic [1:0]    k_quad;
  logic [KW-1:0] k_val;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] out_round;
  logic [KW-1:0] out_k;
  logic          out_last;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beat_cnt = 0;
  logic [1:0] cur_op = 2'd0;
  logic [40:0] exp_q[$];

  k_round_sequencer #(.ROUND_W(RW), .K_W(KW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opcode(opcode),
    .k_round(k_round), .k_opcode(k_opcode), .k_quad(k_quad), .k_val(k_val),
    .out_valid(out_valid), .out_ready(out_ready), .out_round(out_round),
    .out_k(out_k), .out_last(out_last), .busy(busy), .done(done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub K lookup: real constants where the plan names them, otherwise a
  // tagged value that embeds quadrant and round so a wrong k_quad shows up.
  function automatic logic [31:0] k_ref(logic [1:0] op, logic [7:0] r, logic [1:0] q);
    case (op)
      2'd0: begin
        if (r == 8'd0)       k_ref = 32'hd76aa478;
        else if (r == 8'd63) k_ref = 32'heb86d391;
        else                 k_ref = {8'h4d, 6'd0, q, 8'd0, r};
      end
      2'd1: begin
        case (q)
          2'd0:    k_ref = 32'h5a827999;
          2'd1:    k_ref = 32'h6ed9eba1;
          2'd2:    k_ref = 32'h8f1bbcdc;
          default: k_ref = 32'hca62c1d6;
        endcase
      end
      default: begin
        if (r == 8'd0)      k_ref = 32'h428a2f98;
        else if (r == 8'd5) k_ref = 32'h59f111f1;
        else                k_ref = {8'h52, 6'd0, q, 8'd0, r};
      end
    endcase
  endfunction

  function automatic logic [1:0] quad_ref(logic [1:0] op, logic [7:0] r);
    if (op == 2'd0)      quad_ref = r[5:4];
    else if (op == 2'd1) quad_ref = 2'(r / 8'd20);
    else                 quad_ref = 2'd0;
  endfunction

  assign k_val = k_ref(k_opcode, k_round, k_quad);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks (called at a falling edge)
  task automatic push_hash(input logic [1:0] op);
    int n;
    n = (op == 2'd1) ? 80 : 64;
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), 8'(i), k_ref(op, 8'(i), quad_ref(op, 8'(i)))});
  endtask

  task automatic issue_start(input logic [1:0] op, output int c);
    start    = 1'b1;
    opcode   = op;
    c        = cyc;
    cur_op   = op;
    beat_cnt = 0;
    push_hash(op);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] op);
    start  = 1'b1;
    opcode = op;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_beat(input int r);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (out_valid && out_round == 8'(r)) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout_beat: round %0d never presented, expected within 300 cycles", r);
  endtask

  task automatic wait_kround(input int r);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy && k_round == 8'(r)) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout_kround: k_round %0d never seen, expected within 300 cycles", r);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL timeout_done: done never pulsed, expected within 300 cycles");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_out_round"}, out_round, 0);
    check({tag, "_out_k"},     out_k,     0);
    check({tag, "_k_round"},   k_round,   0);
    check({tag, "_k_quad"},    k_quad,    0);
    check({tag, "_k_opcode"},  k_opcode,  0);
  endtask

  // scoreboard monitor: sampled after the falling edge drivers have settled
  initial begin
    logic [40:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && out_valid && out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: round %0d accepted, expected none", out_round);
        end else begin
          e = exp_q.pop_front();
          check("beat_round", 64'(out_round), 64'(e[39:32]));
          check("beat_k", 64'(out_k), 64'(e[31:0]));
          check("beat_last", 64'(out_last), 64'(e[40]));
        end
      end
      if (busy) begin
        check("k_quad", 64'(k_quad), 64'(quad_ref(cur_op, k_round)));
        check("k_opcode", 64'(k_opcode), 64'(cur_op));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // directed sequence
  initial begin
    int c, c2, dc;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // MD5, ready always high
    issue_start(2'd0, c);
    check("md5_busy_cycle1", busy, 1);
    check("md5_valid_cycle1", out_valid, 0);
    wait_beat(0);
    check("md5_first_beat_cycle", 64'(cyc - c), 2);
    check("md5_k0", out_k, 32'hd76aa478);
    wait_kround(16);
    check("md5_quad16", k_quad, 2'd1);
    wait_beat(63);
    check("md5_k63", out_k, 32'heb86d391);
    check("md5_last63", out_last, 1);
    check("md5_beat63_cycle", 64'(cyc - c), 65);
    wait_done(dc);
    check("md5_done_cycle", 64'(dc - c), 66);
    check("md5_busy_in_done", busy, 0);
    check("md5_queue_empty", 64'(exp_q.size()), 0);
    check("md5_beats", 64'(beat_cnt), 64);
    @(negedge clk);
    check("md5_done_pulse", done, 0);

    // SHA-1 quadrants
    issue_start(2'd1, c);
    wait_beat(19);
    check("sha1_k19", out_k, 32'h5a827999);
    wait_beat(20);
    check("sha1_k20", out_k, 32'h6ed9eba1);
    wait_beat(79);
    check("sha1_k79", out_k, 32'hca62c1d6);
    check("sha1_last79", out_last, 1);
    wait_done(dc);
    check("sha1_done_cycle", 64'(dc - c), 82);
    check("sha1_beats", 64'(beat_cnt), 80);
    check("sha1_queue_empty", 64'(exp_q.size()), 0);

    // SHA-256 with three stall cycles on round 5
    issue_start(2'd2, c);
    wait_beat(5);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid_held", out_valid, 1);
      check("bp_round_held", out_round, 8'd5);
      check("bp_k_held", out_k, 32'h59f111f1);
    end
    out_ready = 1'b1;
    wait_done(dc);
    check("bp_done_cycle", 64'(dc - c), 69);
    check("bp_beats", 64'(beat_cnt), 64);
    check("bp_queue_empty", 64'(exp_q.size()), 0);

    // start during RUN and FLUSH is ignored
    issue_start(2'd1, c);
    wait_beat(40);
    pulse_start(2'd0);
    wait_beat(79);
    out_ready = 1'b0;
    start = 1'b1;
    opcode = 2'd2;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    wait_done(dc);
    check("ign_done_cycle", 64'(dc - c), 83);
    check("ign_beats", 64'(beat_cnt), 80);
    check("ign_queue_empty", 64'(exp_q.size()), 0);
    @(negedge clk);
    check("ign_idle_after", busy, 0);

    // reset mid-hash at round 30
    issue_start(2'd0, c);
    wait_beat(30);
    #3 reset_n = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    check("abort_no_done_a", done, 0);
    @(negedge clk);
    check("abort_no_done_b", done, 0);
    reset_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done_after", done, 0);
      check("abort_idle_valid", out_valid, 0);
    end

    // fresh hash, then a new start in the done cycle
    issue_start(2'd3, c);
    wait_beat(0);
    check("fresh_first_cycle", 64'(cyc - c), 2);
    check("fresh_k0", out_k, 32'h428a2f98);
    wait_done(dc);
    check("fresh_done_cycle", 64'(dc - c), 66);
    check("fresh_queue_empty", 64'(exp_q.size()), 0);
    issue_start(2'd0, c2);
    wait_beat(0);
    check("b2b_first_beat_after_done", 64'(cyc - dc), 2);
    check("b2b_k0", out_k, 32'hd76aa478);
    wait_done(dc);
    check("b2b_done_cycle", 64'(dc - c2), 66);
    check("b2b_queue_empty", 64'(exp_q.size()), 0);
    check("b2b_beats", 64'(beat_cnt), 64);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
